// File: rtl/brk_pkg.sv
// Shared types and width helpers for the Breakout brick-field controller.
package brk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CLEAR  = 2'd1,
    ST_REFILL = 2'd2
  } brk_state_e;

  // Index width for n items, never below one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Largest value a hit-point counter of hp_w bits can hold.
  function automatic int unsigned hp_max(input int unsigned hp_w);
    return (1 << hp_w) - 1;
  endfunction

endpackage

// File: rtl/brk_row_hp.sv
// One row of brick hit-point counters with bulk load and single-column decrement.
module brk_row_hp
  import brk_pkg::*;
#(
  parameter  int unsigned BRKS_PER_ROW = 8,
  parameter  int unsigned HP_W         = 2,
  localparam int unsigned CW           = idx_w(BRKS_PER_ROW)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [HP_W-1:0]         ld_val,
  input  logic                    dec,
  input  logic [CW-1:0]           col,
  output logic [BRKS_PER_ROW-1:0] alive,
  output logic                    empty,
  output logic                    hp_one
);

  logic [BRKS_PER_ROW-1:0][HP_W-1:0] hp;

  // HP counters: reset to one hit, load wins over decrement.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < int'(BRKS_PER_ROW); c++) hp[c] <= HP_W'(1);
    end else if (load) begin
      for (int c = 0; c < int'(BRKS_PER_ROW); c++) hp[c] <= ld_val;
    end else if (dec) begin
      for (int c = 0; c < int'(BRKS_PER_ROW); c++)
        if (CW'(c) == col && hp[c] != '0) hp[c] <= hp[c] - HP_W'(1);
    end
  end

  // Alive mask, row-empty flag and "next hit kills" flag for the addressed column.
  always_comb begin
    alive  = '0;
    hp_one = 1'b0;
    for (int c = 0; c < int'(BRKS_PER_ROW); c++) begin
      alive[c] = |hp[c];
      if (CW'(c) == col) hp_one = (hp[c] == HP_W'(1));
    end
    empty = ~|alive;
  end

endmodule

// File: rtl/brk_field_ctrl.sv
// Brick-field controller: hit arbitration, scoring, level advance and row-by-row refill.
module brk_field_ctrl
  import brk_pkg::*;
#(
  parameter  int unsigned NUM_ROWS     = 4,
  parameter  int unsigned BRKS_PER_ROW = 8,
  parameter  int unsigned HP_W         = 2,
  parameter  int unsigned ROW_PTS      = 1,
  parameter  int unsigned LVL_W        = 4,
  parameter  int unsigned CLEAR_DLY    = 16,
  localparam int unsigned RW           = idx_w(NUM_ROWS),
  localparam int unsigned CW           = idx_w(BRKS_PER_ROW),
  localparam int unsigned NB           = NUM_ROWS * BRKS_PER_ROW
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                new_game,
  input  logic                hit_valid,
  input  logic [RW-1:0]       hit_row,
  input  logic [CW-1:0]       hit_col,
  output logic [NB-1:0]       brk_en,
  output logic                hit_ack,
  output logic                score_vld,
  output logic [7:0]          score_pts,
  output logic [NUM_ROWS-1:0] row_empty,
  output logic                field_empty,
  output logic [LVL_W-1:0]    level,
  output logic                busy
);

  localparam int unsigned HP_MAX_V = hp_max(HP_W);
  localparam int unsigned CNT_W    = idx_w(CLEAR_DLY);

  if (ROW_PTS * NUM_ROWS > 255) begin : g_pts_range
    $error("ROW_PTS*NUM_ROWS does not fit the 8-bit score");
  end

  brk_state_e                              state;
  logic [CNT_W-1:0]                        clr_cnt;
  logic [RW-1:0]                           ptr;
  logic [NUM_ROWS-1:0][BRKS_PER_ROW-1:0]   alive;
  logic [NUM_ROWS-1:0][BRKS_PER_ROW-1:0]   alive_after_c;
  logic [NUM_ROWS-1:0]                     row_one;
  logic [NUM_ROWS-1:0]                     row_load_c;
  logic [NUM_ROWS-1:0]                     row_dec_c;
  logic                                    in_range_c;
  logic                                    tgt_alive_c;
  logic                                    tgt_one_c;
  logic                                    accept_c;
  logic                                    last_c;
  logic [HP_W-1:0]                         ld_val_c;
  logic [LVL_W:0]                          lvl_inc_c;
  logic [7:0]                              kill_pts_c;

  for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row
    brk_row_hp #(
      .BRKS_PER_ROW(BRKS_PER_ROW),
      .HP_W        (HP_W)
    ) u_row (
      .clk   (clk),
      .rst   (rst),
      .load  (row_load_c[r]),
      .ld_val(ld_val_c),
      .dec   (row_dec_c[r]),
      .col   (hit_col),
      .alive (alive[r]),
      .empty (row_empty[r]),
      .hp_one(row_one[r])
    );
  end

  assign brk_en      = alive;
  assign field_empty = ~|alive;

  // Hit qualification and the field state as it would be after this hit.
  always_comb begin
    in_range_c    = (32'(hit_row) < NUM_ROWS) && (32'(hit_col) < BRKS_PER_ROW);
    tgt_alive_c   = 1'b0;
    tgt_one_c     = 1'b0;
    alive_after_c = alive;
    if (in_range_c) begin
      tgt_alive_c                    = alive[hit_row][hit_col];
      tgt_one_c                      = row_one[hit_row];
      alive_after_c[hit_row][hit_col] = 1'b0;
    end
    accept_c   = hit_valid && !new_game && (state == ST_IDLE) && in_range_c && tgt_alive_c;
    last_c     = accept_c && tgt_one_c && (alive_after_c == '0);
    kill_pts_c = 8'(ROW_PTS * (NUM_ROWS - 32'(hit_row)));
  end

  // Refill value min(level+1, HP_MAX), plus per-row load and decrement strobes.
  always_comb begin
    lvl_inc_c = {1'b0, level} + (LVL_W + 1)'(1);
    ld_val_c  = (32'(lvl_inc_c) > HP_MAX_V) ? HP_W'(HP_MAX_V) : HP_W'(lvl_inc_c);
    for (int r = 0; r < int'(NUM_ROWS); r++) begin
      row_load_c[r] = (state == ST_REFILL) && !new_game && (ptr == RW'(r));
      row_dec_c[r]  = accept_c && (hit_row == RW'(r));
    end
  end

  // Control FSM with registered ack/score/busy and the level counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      clr_cnt   <= '0;
      ptr       <= '0;
      level     <= '0;
      hit_ack   <= 1'b0;
      score_vld <= 1'b0;
      score_pts <= 8'd0;
      busy      <= 1'b0;
    end else begin
      hit_ack   <= accept_c;
      score_vld <= accept_c;
      score_pts <= accept_c ? (tgt_one_c ? kill_pts_c : 8'd1) : 8'd0;
      if (new_game) begin
        level   <= '0;
        state   <= ST_REFILL;
        ptr     <= '0;
        clr_cnt <= '0;
        busy    <= 1'b1;
      end else begin
        case (state)
          ST_IDLE: begin
            if (last_c) begin
              state   <= ST_CLEAR;
              clr_cnt <= '0;
              busy    <= 1'b1;
              if (level != '1) level <= level + LVL_W'(1);
            end
          end
          ST_CLEAR: begin
            if (clr_cnt == CNT_W'(CLEAR_DLY - 1)) begin
              state <= ST_REFILL;
              ptr   <= '0;
            end else begin
              clr_cnt <= clr_cnt + CNT_W'(1);
            end
          end
          ST_REFILL: begin
            if (ptr == RW'(NUM_ROWS - 1)) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end else begin
              ptr <= ptr + RW'(1);
            end
          end
          default: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_brk_field_ctrl.sv
// Directed bench for brk_field_ctrl: a 4x8 field plus a 4x6 field for column range checks.
module tb_brk_field_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        new_game;
  logic        hit_valid;
  logic [1:0]  hit_row;
  logic [2:0]  hit_col;
  logic [31:0] brk_en;
  logic        hit_ack, score_vld, field_empty, busy;
  logic [7:0]  score_pts;
  logic [3:0]  row_empty;
  logic [3:0]  level;

  logic        h6_valid;
  logic [1:0]  h6_row;
  logic [2:0]  h6_col;
  logic [23:0] brk_en6;
  logic        ack6, vld6, fe6, busy6;
  logic [7:0]  pts6;
  logic [3:0]  re6;
  logic [3:0]  lvl6;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  brk_field_ctrl dut (
    .clk(clk), .rst(rst), .new_game(new_game), .hit_valid(hit_valid),
    .hit_row(hit_row), .hit_col(hit_col), .brk_en(brk_en), .hit_ack(hit_ack),
    .score_vld(score_vld), .score_pts(score_pts), .row_empty(row_empty),
    .field_empty(field_empty), .level(level), .busy(busy)
  );

  brk_field_ctrl #(.BRKS_PER_ROW(6)) dut6 (
    .clk(clk), .rst(rst), .new_game(new_game), .hit_valid(h6_valid),
    .hit_row(h6_row), .hit_col(h6_col), .brk_en(brk_en6), .hit_ack(ack6),
    .score_vld(vld6), .score_pts(pts6), .row_empty(re6),
    .field_empty(fe6), .level(lvl6), .busy(busy6)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_hit(input int r, input int c);
    hit_valid = 1'b1;
    hit_row   = 2'(r);
    hit_col   = 3'(c);
    step(1);
    hit_valid = 1'b0;
  endtask

  task automatic kill_all();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 8; c++)
        for (int k = 0; k < 4 && brk_en[r*8+c]; k++) do_hit(r, c);
  endtask

  initial begin
    rst = 1'b1; new_game = 1'b0; hit_valid = 1'b0; hit_row = '0; hit_col = '0;
    h6_valid = 1'b0; h6_row = '0; h6_col = '0;
    step(2);
    check("rst_brk_en", brk_en, 64'hffff_ffff);
    check("rst_ack", hit_ack, 0);
    check("rst_vld", score_vld, 0);
    check("rst_pts", score_pts, 0);
    check("rst_busy", busy, 0);
    check("rst_level", level, 0);
    check("rst_field_empty", field_empty, 0);
    check("rst_row_empty", row_empty, 0);
    check("rst_brk_en6", brk_en6, 64'hff_ffff);
    rst = 1'b0;
    step(1);

    // First kill at level 0
    do_hit(0, 0);
    check("hit00_ack", hit_ack, 1);
    check("hit00_vld", score_vld, 1);
    check("hit00_pts", score_pts, 4);
    check("hit00_brk_en", brk_en, 64'hffff_fffe);
    // Dead brick is rejected
    do_hit(0, 0);
    check("dead_ack", hit_ack, 0);
    check("dead_vld", score_vld, 0);
    check("dead_pts", score_pts, 0);
    check("dead_brk_en", brk_en, 64'hffff_fffe);

    // Column out of range on the 6-wide field
    h6_valid = 1'b1; h6_row = 2'd0; h6_col = 3'd7;
    step(1);
    h6_valid = 1'b0;
    check("col7_ack6", ack6, 0);
    check("col7_vld6", vld6, 0);
    check("col7_brk_en6", brk_en6, 64'hff_ffff);
    h6_valid = 1'b1; h6_row = 2'd0; h6_col = 3'd5;
    step(1);
    h6_valid = 1'b0;
    check("col5_pts6", pts6, 4);
    check("col5_brk_en6", brk_en6, 64'hff_ffdf);

    // Clear the rest of the field; row weight decides the score
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 8; c++)
        if (!(r == 0 && c == 0)) begin
          do_hit(r, c);
          check($sformatf("kill_pts_r%0d_c%0d", r, c), score_pts, 64'(4 - r));
        end
    check("clr_field_empty", field_empty, 1);
    check("clr_row_empty", row_empty, 4'hf);
    check("clr_level", level, 1);
    check("clr_busy", busy, 1);
    check("clr_last_vld", score_vld, 1);

    // Hit while busy is ignored (1st CLEAR cycle)
    do_hit(2, 2);
    check("busy_hit_ack", hit_ack, 0);
    step(15);
    check("clr_end_brk_en", brk_en, 0);
    check("clr_end_busy", busy, 1);
    step(1);
    check("refill_r0", brk_en, 64'h0000_00ff);
    step(1);
    check("refill_r1", brk_en, 64'h0000_ffff);
    step(1);
    check("refill_r2", brk_en, 64'h00ff_ffff);
    check("refill_r2_busy", busy, 1);
    step(1);
    check("refill_r3", brk_en, 64'hffff_ffff);
    check("refill_done_busy", busy, 0);

    // Level 1 bricks take two hits
    do_hit(1, 2);
    check("hp2_first_pts", score_pts, 1);
    check("hp2_first_brk_en", brk_en, 64'hffff_ffff);
    do_hit(1, 2);
    check("hp2_kill_pts", score_pts, 3);
    check("hp2_kill_brk_en", brk_en, 64'hffff_fbff);

    // Clear at level 1 -> level 2, stop refill at ptr=2
    kill_all();
    check("lvl2_level", level, 2);
    check("lvl2_busy", busy, 1);
    step(18);
    check("mid_refill_brk_en", brk_en, 64'h0000_ffff);
    new_game = 1'b1; hit_valid = 1'b1; hit_row = 2'd0; hit_col = 3'd0;
    step(1);
    new_game = 1'b0; hit_valid = 1'b0;
    check("ng_level", level, 0);
    check("ng_ack", hit_ack, 0);
    check("ng_vld", score_vld, 0);
    check("ng_busy", busy, 1);
    check("ng_brk_en", brk_en, 64'h0000_ffff);
    step(3);
    check("ng_r2_busy", busy, 1);
    step(1);
    check("ng_done_brk_en", brk_en, 64'hffff_ffff);
    check("ng_done_busy", busy, 0);
    do_hit(0, 0);
    check("ng_hp1_pts", score_pts, 4);
    check("ng_hp1_brk_en", brk_en, 64'hffff_fffe);
    do_hit(2, 3);
    check("ng_hp1_pts_r2", score_pts, 2);

    // Asynchronous reset in the middle of CLEAR
    kill_all();
    check("clr2_busy", busy, 1);
    check("clr2_level", level, 1);
    step(3);
    #2;
    rst = 1'b1;
    #1;
    check("arst_brk_en", brk_en, 64'hffff_ffff);
    check("arst_busy", busy, 0);
    check("arst_level", level, 0);
    check("arst_field_empty", field_empty, 0);
    check("arst_ack", hit_ack, 0);
    check("arst_brk_en6", brk_en6, 64'hff_ffff);
    step(1);
    rst = 1'b0;
    step(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
